if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter and drives the instruction ROM read port with chip-enable and word address. It captures the returned instruction into the IF/ID pipeline register and handles downstream stall, branch/jump redirect with MIPS delay-slot semantics, pipeline flush, and misaligned-target detection.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0000: instruction word inserted as a bubble.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst`  in  1  : reset, synchronous, active-high (`RST_ENABLE` = 1).
- `stall`  in  1  : from hazard unit; hold PC and IF/ID.
- `flush`  in  1  : from exception/control; redirect and bubble IF/ID.
- `flush_pc`  in  32  : redirect address used with `flush`.
- `branch_flag`  in  1  : from ID; taken branch or jump.
- `branch_target`  in  32  : target address from ID.
- `rom_ce`  out  1  : ROM read enable (`ROMCE_ENABLE` = 1).
- `rom_addr`  out  32  : byte address to ROM; equals current PC.
- `rom_data`  in  32  : combinational ROM read data for `rom_addr`.
- `id_pc`  out  32  : IF/ID PC.
- `id_inst`  out  32  : IF/ID instruction.
- `id_valid`  out  1  : IF/ID holds a real instruction.
- `fetch_err`  out  1  : sticky misaligned-fetch flag.
- `err_pc`  out  32  : offending address when `fetch_err` is set.

## Operation
- States: `S_IDLE`, `S_RUN`, `S_HALT`.
- Reset (`rst`=1 at an edge): state to `S_IDLE`, PC to `RESET_PC`, `rom_ce`=0, `id_pc`=0, `id_inst`=`NOP_INST`, `id_valid`=0, `fetch_err`=0, `err_pc`=0, pending-branch register cleared.
- `S_IDLE`: `rom_ce`=0 and PC held. Next edge moves to `S_RUN`.
- `S_RUN`: `rom_ce`=1. Priority at each edge is flush > stall > branch > pending > sequential.
  - `flush`: PC to `flush_pc`. IF/ID gets a bubble (`id_valid`=0, `id_inst`=`NOP_INST`). Pending branch cleared.
  - `stall`: PC and IF/ID hold. If `branch_flag`=1, latch `branch_target` into the pending register. A later branch during the same stall overwrites it.
  - Otherwise: IF/ID gets {PC, `rom_data`, 1}. Next PC is `branch_target` if `branch_flag`, else the pending target if one is set (then cleared), else PC+4.
- Delay slot: the instruction in IF when ID asserts `branch_flag` is the delay slot. It is captured normally and is never squashed by a branch.
- Misalignment: if the selected next PC has bits [1:0]≠0, the stage goes to `S_HALT`. It sets `fetch_err`=1 and `err_pc` to that address, PC holds its old value, and IF/ID gets a bubble.
- `S_HALT`: `rom_ce`=0 and IF/ID holds a bubble. Only `flush` with an aligned `flush_pc`, or `rst`, leaves `S_HALT` (to `S_RUN`). A flush clears `fetch_err`. A flush to a misaligned `flush_pc` stays in or enters `S_HALT`.
- PC+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

## Timing
- `rom_addr` is PC, registered, so there is no combinational path from inputs to `rom_addr`.
- `rom_ce` is registered from state: low in the first cycle after reset release, high from the second.
- ROM data for PC is sampled in the same cycle. IF/ID is valid one cycle after PC is presented (1-cycle latency).
- A branch asserted in cycle N changes `rom_addr` to the target in cycle N+1.
- A branch during stall takes effect on the first non-stalled edge.
- A flush wins over a simultaneous stall and branch.
- `rst` wins over everything, including mid-stall and `S_HALT`.

## Structure
- Add to shared `def.v`: `RST_ENABLE`/`RST_DISABLE`, `ROMCE_ENABLE`/`ROMCE_DISABLE`, `NOP_INST`, `RESET_PC`, and state encodings `S_IDLE`/`S_RUN`/`S_HALT`.
- One sub-module, `pc_reg`: PC register, next-PC mux, pending-branch register and misalignment check.
- The IF/ID register and the FSM live in `if_stage`.

## Test plan
Use the instruction ROM preloaded with the standard test program.

- Reset: hold `rst` for 3 cycles, then release → `rom_ce`=0 for 1 cycle; `rom_addr` then steps 0, 4, 8. `id_inst` shows 3463000a, 34840001, 34210000 with `id_valid`=1 from the third post-reset cycle.
- Jump: pulse `branch_flag` with target 0x18 while `rom_addr`=0x10 → IF/ID captures 8c060004 (delay slot), next `rom_addr`=0x18, then `id_inst`=00441020.
- Stall with branch: assert `stall` for 2 cycles at `rom_addr`=0x8 and pulse `branch_flag` (target 0x24) during the stall → PC and IF/ID frozen. The first edge after the stall drops captures 34210000 and `rom_addr` becomes 0x24.
- Flush: assert `flush`, `stall` and `branch_flag` together with `flush_pc`=0x4 → `id_valid`=0 next cycle, `rom_addr`=0x4, pending branch discarded.
- Misalignment: branch to 0x1A → `fetch_err`=1, `err_pc`=0x1A, `rom_ce`=0, `id_valid`=0 held. Then flush to 0x0 → `S_RUN`, `fetch_err`=0, fetch resumes at 0.
- Wrap: flush to 0xFFFF_FFFC with a ROM model returning NOP → next `rom_addr`=0x0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds reset/ROM-enable polarities, default reset PC and bubble instruction,
// and the fetch FSM state encoding.
package if_stage_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic RST_DISABLE   = 1'b0;
  localparam logic ROMCE_ENABLE  = 1'b1;
  localparam logic ROMCE_DISABLE = 1'b0;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // True when a fetch address is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter for the fetch stage.
// Selects the next PC (flush > stall > branch > pending branch > PC+4), keeps a
// pending-branch register for branches that arrive while stalled, and flags a
// misaligned selected target.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   advance         : PC/pending registers may update this edge
//   flush, flush_pc : redirect request and address
//   stall           : hold PC, remember any branch in the pending register
//   branch_flag     : taken branch/jump from ID, with branch_target
//   pc              : current PC
//   next_pc         : selected next PC (before the misalignment check)
//   misaligned      : next_pc is not word aligned
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic        pend_valid;
  logic [31:0] pend_target;

  always_comb begin
    if (flush) begin
      next_pc = flush_pc;
    end else if (stall) begin
      next_pc = pc;
    end else if (branch_flag) begin
      next_pc = branch_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc + 32'd4;  // modulo 2^32, so 0xFFFF_FFFC wraps to 0
    end
  end

  assign misaligned = is_misaligned(next_pc);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else if (advance) begin
      // A misaligned target never reaches the PC; the old value is kept.
      if (!misaligned) begin
        pc <= next_pc;
      end
      if (flush) begin
        pend_valid <= 1'b0;
      end else if (stall) begin
        // Latest branch seen during the stall wins.
        if (branch_flag) begin
          pend_valid  <= 1'b1;
          pend_target <= branch_target;
        end
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Drives the instruction ROM from the PC, captures the returned word into the
// IF/ID register and handles stall, branch/jump (with delay slot), flush and
// misaligned-target halting.
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   stall                     : hold PC and IF/ID
//   flush, flush_pc           : redirect and bubble IF/ID
//   branch_flag, branch_target: taken branch/jump from ID
//   rom_ce, rom_addr, rom_data: ROM read port (rom_data is combinational)
//   id_pc, id_inst, id_valid  : IF/ID pipeline register
//   fetch_err, err_pc         : sticky misaligned-fetch flag and address
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        fetch_err,
  output logic [31:0] err_pc
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         advance;

  // In S_HALT only a flush may move the PC.
  assign advance  = (state == S_RUN) || ((state == S_HALT) && flush);
  assign rom_addr = pc;

  if_stage_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .advance      (advance),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  // FSM plus IF/ID register; rom_ce tracks the next state so it is registered.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= S_IDLE;
      rom_ce    <= ROMCE_DISABLE;
      id_pc     <= 32'h0;
      id_inst   <= NOP_INST;
      id_valid  <= 1'b0;
      fetch_err <= 1'b0;
      err_pc    <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state  <= S_RUN;
          rom_ce <= ROMCE_ENABLE;
        end
        S_RUN: begin
          if (misaligned) begin
            state     <= S_HALT;
            rom_ce    <= ROMCE_DISABLE;
            fetch_err <= 1'b1;
            err_pc    <= next_pc;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
          end else if (flush) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
          end else if (!stall) begin
            // Delay-slot instruction is captured even when a branch is taken.
            id_pc    <= pc;
            id_inst  <= rom_data;
            id_valid <= 1'b1;
          end
        end
        S_HALT: begin
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
          if (flush) begin
            if (misaligned) begin
              fetch_err <= 1'b1;
              err_pc    <= next_pc;
            end else begin
              state     <= S_RUN;
              rom_ce    <= ROMCE_ENABLE;
              fetch_err <= 1'b0;
              err_pc    <= 32'h0;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          rom_ce <= ROMCE_DISABLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a small preloaded ROM.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        fetch_err;
  logic [31:0] err_pc;

  logic [31:0] rom [16];
  int checks;
  int failures;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .fetch_err    (fetch_err),
    .err_pc       (err_pc)
  );

  // Addresses outside the program return NOP.
  assign rom_data = (rom_addr < 32'd64) ? rom[rom_addr[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = 32'h3463000a;
    rom[1] = 32'h34840001;
    rom[2] = 32'h34210000;
    rom[3] = 32'h20a50002;
    rom[4] = 32'h8c060004;
    rom[5] = 32'hac060008;
    rom[6] = 32'h00441020;
    rom[7] = 32'h00000000;
    rom[9] = 32'h1000ffff;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;
    tick(); tick(); tick();
    check_eq("rst_rom_ce", {31'h0, rom_ce}, 32'h0);
    check_eq("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check_eq("rst_id_inst", id_inst, 32'h0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    check_eq("rst_err_pc", err_pc, 32'h0);
    check_eq("rst_rom_addr", rom_addr, 32'h0);

    // Release: one idle cycle, then sequential fetch.
    rst = 1'b0;
    tick();
    check_eq("run_rom_ce", {31'h0, rom_ce}, 32'h1);
    check_eq("run_addr0", rom_addr, 32'h0);
    check_eq("run_valid0", {31'h0, id_valid}, 32'h0);
    tick();
    check_eq("seq_addr4", rom_addr, 32'h4);
    check_eq("seq_inst0", id_inst, 32'h3463000a);
    check_eq("seq_valid0", {31'h0, id_valid}, 32'h1);
    check_eq("seq_pc0", id_pc, 32'h0);
    tick();
    check_eq("seq_addr8", rom_addr, 32'h8);
    check_eq("seq_inst1", id_inst, 32'h34840001);

    // Stall for two cycles with a branch to 0x24 in the first.
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h24;
    tick();
    check_eq("stall_addr_a", rom_addr, 32'h8);
    check_eq("stall_inst_a", id_inst, 32'h34840001);
    branch_flag = 1'b0;
    tick();
    check_eq("stall_addr_b", rom_addr, 32'h8);
    check_eq("stall_inst_b", id_inst, 32'h34840001);
    stall = 1'b0;
    tick();
    check_eq("pend_inst", id_inst, 32'h34210000);
    check_eq("pend_pc", id_pc, 32'h8);
    check_eq("pend_addr", rom_addr, 32'h24);
    tick();
    check_eq("pend_after_addr", rom_addr, 32'h28);
    check_eq("pend_after_inst", id_inst, 32'h1000ffff);

    // Flush beats simultaneous stall + branch; the stalled branch is dropped.
    flush = 1'b1; flush_pc = 32'h4; stall = 1'b1;
    branch_flag = 1'b1; branch_target = 32'h30;
    tick();
    check_eq("flush_valid", {31'h0, id_valid}, 32'h0);
    check_eq("flush_inst", id_inst, 32'h0);
    check_eq("flush_addr", rom_addr, 32'h4);
    flush = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    tick();
    check_eq("flush_nopend_addr", rom_addr, 32'h8);
    check_eq("flush_nopend_inst", id_inst, 32'h34840001);
    tick();
    tick();
    check_eq("jmp_pre_addr", rom_addr, 32'h10);

    // Jump at 0x10 to 0x18: delay slot captured, then target.
    branch_flag = 1'b1; branch_target = 32'h18;
    tick();
    check_eq("jmp_slot_inst", id_inst, 32'h8c060004);
    check_eq("jmp_addr", rom_addr, 32'h18);
    branch_flag = 1'b0;
    tick();
    check_eq("jmp_tgt_inst", id_inst, 32'h00441020);
    check_eq("jmp_tgt_pc", id_pc, 32'h18);

    // Misaligned branch target halts the stage.
    branch_flag = 1'b1; branch_target = 32'h1a;
    tick();
    branch_flag = 1'b0;
    check_eq("mis_err", {31'h0, fetch_err}, 32'h1);
    check_eq("mis_err_pc", err_pc, 32'h1a);
    check_eq("mis_rom_ce", {31'h0, rom_ce}, 32'h0);
    check_eq("mis_valid", {31'h0, id_valid}, 32'h0);
    check_eq("mis_addr", rom_addr, 32'h1c);
    tick();
    check_eq("halt_err", {31'h0, fetch_err}, 32'h1);
    check_eq("halt_valid", {31'h0, id_valid}, 32'h0);
    check_eq("halt_rom_ce", {31'h0, rom_ce}, 32'h0);
    flush = 1'b1; flush_pc = 32'h2;
    tick();
    check_eq("halt_misflush_err", {31'h0, fetch_err}, 32'h1);
    check_eq("halt_misflush_pc", err_pc, 32'h2);
    check_eq("halt_misflush_ce", {31'h0, rom_ce}, 32'h0);
    flush_pc = 32'h0;
    tick();
    check_eq("recover_err", {31'h0, fetch_err}, 32'h0);
    check_eq("recover_ce", {31'h0, rom_ce}, 32'h1);
    check_eq("recover_addr", rom_addr, 32'h0);
    check_eq("recover_valid", {31'h0, id_valid}, 32'h0);
    flush = 1'b0;
    tick();
    check_eq("resume_inst", id_inst, 32'h3463000a);
    check_eq("resume_addr", rom_addr, 32'h4);

    // PC+4 wraps at the top of the address space.
    flush = 1'b1; flush_pc = 32'hffff_fffc;
    tick();
    check_eq("wrap_pre_addr", rom_addr, 32'hffff_fffc);
    flush = 1'b0;
    tick();
    check_eq("wrap_addr", rom_addr, 32'h0);
    check_eq("wrap_inst", id_inst, 32'h0);
    check_eq("wrap_pc", id_pc, 32'hffff_fffc);
    check_eq("wrap_valid", {31'h0, id_valid}, 32'h1);
    tick();
    check_eq("wrap_next_inst", id_inst, 32'h3463000a);

    // Reset during a stall.
    stall = 1'b1; rst = 1'b1;
    tick();
    check_eq("rst2_ce", {31'h0, rom_ce}, 32'h0);
    check_eq("rst2_valid", {31'h0, id_valid}, 32'h0);
    check_eq("rst2_addr", rom_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
